// File: rtl/booth_sequencer_if.sv
// Bus bundle between the Booth sequencer and its environment: operand load,
// external ALU operand/result path and completion status.
interface booth_sequencer_if #(
    parameter int unsigned WIDTH = 16
);

    logic                   start_in;
    logic [WIDTH-1:0]       multiplicand_in;
    logic [WIDTH-1:0]       multiplier_in;
    logic [WIDTH-1:0]       alu_A_out;
    logic [WIDTH-1:0]       alu_B_out;
    logic                   alu_op_out;
    logic [WIDTH-1:0]       alu_result_in;
    logic                   busy_out;
    logic                   done_out;
    logic [2*WIDTH-1:0]     product_out;

    // Sequencer side
    modport slave (
        input  start_in,
        input  multiplicand_in,
        input  multiplier_in,
        input  alu_result_in,
        output alu_A_out,
        output alu_B_out,
        output alu_op_out,
        output busy_out,
        output done_out,
        output product_out
    );

    // Requester / ALU side
    modport master (
        output start_in,
        output multiplicand_in,
        output multiplier_in,
        output alu_result_in,
        input  alu_A_out,
        input  alu_B_out,
        input  alu_op_out,
        input  busy_out,
        input  done_out,
        input  product_out
    );

endinterface

// File: rtl/booth_sequencer.sv
// Radix-2 Booth multiplier sequencer: one multiplier bit per cycle, all
// add/subtract work done by an external combinational ALU. WIDTH must be >= 2.
module booth_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk_in,
    input  logic               reset_in,
    booth_sequencer_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned MSB   = WIDTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITERATE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    state_e                 state_q;
    logic [WIDTH-1:0]       a_q;
    logic [WIDTH-1:0]       q_q;
    logic                   qm1_q;
    logic [WIDTH-1:0]       m_q;
    logic [CNT_W-1:0]       count_q;
    logic [2*WIDTH-1:0]     product_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   op_q;

    logic                   do_sub_c;
    logic                   do_add_c;
    logic [WIDTH-1:0]       r_c;
    logic                   ov_c;
    logic                   sign_c;
    logic                   last_c;
    logic [WIDTH-1:0]       a_d;
    logic [WIDTH-1:0]       q_d;
    logic                   qm1_d;
    logic [CNT_W-1:0]       count_d;

    // Booth pair decode: 10 subtracts M, 01 adds M, 00/11 pass A through
    assign do_sub_c = q_q[0] & ~qm1_q;
    assign do_add_c = ~q_q[0] & qm1_q;
    assign last_c   = (count_q == CNT_W'(1));

    // One iteration: select R, recover the true sign of the WIDTH+1-bit sum, then shift
    always_comb begin
        r_c  = a_q;
        ov_c = 1'b0;
        if (do_sub_c) begin
            r_c  = bus.alu_result_in;
            ov_c = (a_q[MSB] != m_q[MSB]) && (r_c[MSB] != a_q[MSB]);
        end else if (do_add_c) begin
            r_c  = bus.alu_result_in;
            ov_c = (a_q[MSB] == m_q[MSB]) && (r_c[MSB] != a_q[MSB]);
        end
        // The extra sign bit keeps the product exact when M is the most negative value
        sign_c  = r_c[MSB] ^ ov_c;
        a_d     = {sign_c, r_c[WIDTH-1:1]};
        q_d     = {r_c[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q - CNT_W'(1);
    end

    // Control FSM and datapath registers; status outputs are registered alongside the state
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        state_q <= ST_ITERATE;
                        a_q     <= '0;
                        q_q     <= bus.multiplier_in;
                        qm1_q   <= 1'b0;
                        m_q     <= bus.multiplicand_in;
                        count_q <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        // First pair is {Q[0], 0}: subtract exactly when Q[0] is set
                        op_q    <= bus.multiplier_in[0];
                    end
                end
                ST_ITERATE: begin
                    a_q     <= a_d;
                    q_q     <= q_d;
                    qm1_q   <= qm1_d;
                    count_q <= count_d;
                    if (last_c) begin
                        state_q   <= ST_DONE;
                        product_q <= {a_d, q_d};
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        op_q      <= 1'b0;
                    end else begin
                        op_q      <= q_d[0] & ~qm1_d;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    op_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_A_out   = a_q;
    assign bus.alu_B_out   = m_q;
    assign bus.alu_op_out  = op_q;
    assign bus.busy_out    = busy_q;
    assign bus.done_out    = done_q;
    assign bus.product_out = product_q;

endmodule
